retire_trace_buffer: RTL and testbench

Retirement trace buffer that sits directly downstream of the pipelined core's writeback stage. It samples the per-instruction retire record the core presents (PC, immediate, register indices, RegWrite, exception, valid) and queues it in a FIFO. A valid/ready port drains the queue to a debug or trace consumer. The block also keeps cycle and retired-instruction counters, detects and counts dropped records, and freezes capture on the first exception, because the core holds its writeback stage static after an exception.

---
 rtl/retire_trace_buffer.sv | 179 +++++++++++++++++
 tb/tb_retire_trace_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// Purpose: captures core retire records into a FIFO for a trace consumer; keeps cycle/instret counters, counts drops, freezes on exception.
// Latency: 1 cycle from retire sample to t_valid (no combinational fall-through); counters and status update on the same edge as the event.
// Backpressure: t_ready low holds the head stable; a retire that finds the FIFO full (and no pop that cycle) is dropped and counted.
module retire_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ret_valid,
    input  logic [31:0]   ret_pc,
    input  logic [31:0]   ret_imm,
    input  logic [4:0]    ret_rs1,
    input  logic [4:0]    ret_rs2,
    input  logic [4:0]    ret_rd,
    input  logic          ret_regwrite,
    input  logic          ret_exception,
    input  logic          clr,
    output logic          t_valid,
    input  logic          t_ready,
    output logic [31:0]   t_pc,
    output logic [31:0]   t_imm,
    output logic [4:0]    t_rs1,
    output logic [4:0]    t_rs2,
    output logic [4:0]    t_rd,
    output logic          t_regwrite,
    output logic          t_exception,
    output logic [15:0]   t_seq,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic [15:0]   drop_count,
    output logic          halted,
    output logic [63:0]   cycle_count,
    output logic [63:0]   instret
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regwrite;
        logic        exception;
        logic [15:0] seq;
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          wr_rec;
    rec_t          head;

    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0] level_q,    level_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q,     drop_d;
    logic          halted_q,   halted_d;
    logic [63:0]   cycle_q,    cycle_d;
    logic [63:0]   instret_q,  instret_d;

    logic          ev;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;

    // Event decode: a retire counts only when not frozen and not being flushed;
    // a full FIFO still accepts when the head leaves in the same cycle.
    always_comb begin
        ev   = ret_valid & ~halted_q & ~clr;
        pop  = (level_q != '0) & t_ready;
        full = (level_q == FULL_LVL);
        push = ev & (~full | pop);
        drop = ev & ~push;

        wr_rec.pc        = ret_pc;
        wr_rec.imm       = ret_imm;
        wr_rec.rs1       = ret_rs1;
        wr_rec.rs2       = ret_rs2;
        wr_rec.rd        = ret_rd;
        wr_rec.regwrite  = ret_regwrite;
        wr_rec.exception = ret_exception;
        wr_rec.seq       = instret_q[15:0];
    end

    // Next-state: clr wins over push/pop and status, but leaves the free-running counters alone.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        halted_d   = halted_q;
        cycle_d    = halted_q ? cycle_q : cycle_q + 64'd1;
        instret_d  = ev ? instret_q + 64'd1 : instret_q;

        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
            halted_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
            // The core holds writeback static after an exception, so stop sampling to avoid duplicates.
            if (ev & ret_exception) begin
                halted_d = 1'b1;
            end
        end
    end

    // Control and counter registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            halted_q   <= 1'b0;
            cycle_q    <= '0;
            instret_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            halted_q   <= halted_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
        end
    end

    // Record storage; no reset needed because the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    // Head presentation: zero when empty so reset leaves every output at 0.
    always_comb begin
        head = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    end

    assign t_valid     = (level_q != '0);
    assign t_pc        = head.pc;
    assign t_imm       = head.imm;
    assign t_rs1       = head.rs1;
    assign t_rs2       = head.rs2;
    assign t_rd        = head.rd;
    assign t_regwrite  = head.regwrite;
    assign t_exception = head.exception;
    assign t_seq       = head.seq;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ret_valid;
    logic [31:0]   ret_pc;
    logic [31:0]   ret_imm;
    logic [4:0]    ret_rs1;
    logic [4:0]    ret_rs2;
    logic [4:0]    ret_rd;
    logic          ret_regwrite;
    logic          ret_exception;
    logic          clr;
    logic          t_valid;
    logic          t_ready;
    logic [31:0]   t_pc;
    logic [31:0]   t_imm;
    logic [4:0]    t_rs1;
    logic [4:0]    t_rs2;
    logic [4:0]    t_rd;
    logic          t_regwrite;
    logic          t_exception;
    logic [15:0]   t_seq;
    logic [LW-1:0] level;
    logic          overflow;
    logic [15:0]   drop_count;
    logic          halted;
    logic [63:0]   cycle_count;
    logic [63:0]   instret;

    retire_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_imm(ret_imm),
        .ret_rs1(ret_rs1), .ret_rs2(ret_rs2), .ret_rd(ret_rd),
        .ret_regwrite(ret_regwrite), .ret_exception(ret_exception),
        .clr(clr),
        .t_valid(t_valid), .t_ready(t_ready),
        .t_pc(t_pc), .t_imm(t_imm), .t_rs1(t_rs1), .t_rs2(t_rs2), .t_rd(t_rd),
        .t_regwrite(t_regwrite), .t_exception(t_exception), .t_seq(t_seq),
        .level(level), .overflow(overflow), .drop_count(drop_count),
        .halted(halted), .cycle_count(cycle_count), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regwrite;
        logic        exception;
        logic [15:0] seq;
    } rec_t;

    // Reference model: a queue of records plus plain counters.
    rec_t        mq[$];
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    logic        m_ovf;
    int          m_drop;
    logic        m_halt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t head_obs();
        rec_t r;
        r.pc = t_pc; r.imm = t_imm; r.rs1 = t_rs1; r.rs2 = t_rs2; r.rd = t_rd;
        r.regwrite = t_regwrite; r.exception = t_exception; r.seq = t_seq;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cycle = '0; m_instret = '0; m_ovf = 1'b0; m_drop = 0; m_halt = 1'b0;
    endtask

    task automatic model_edge();
        logic ev;
        logic pop;
        logic was_halt;
        rec_t r;
        was_halt = m_halt;
        ev  = ret_valid && !m_halt && !clr;
        pop = (mq.size() != 0) && t_ready;
        r   = '0;
        if (ev) begin
            r.pc = ret_pc; r.imm = ret_imm; r.rs1 = ret_rs1; r.rs2 = ret_rs2; r.rd = ret_rd;
            r.regwrite = ret_regwrite; r.exception = ret_exception; r.seq = m_instret[15:0];
            m_instret = m_instret + 64'd1;
        end
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0; m_drop = 0; m_halt = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (ev) begin
                if (mq.size() < DEPTH) mq.push_back(r);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
                if (ret_exception) m_halt = 1'b1;
            end
        end
        if (!was_halt) m_cycle = m_cycle + 64'd1;
    endtask

    task automatic check_all();
        chk("t_valid", t_valid, mq.size() != 0);
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drop);
        chk("halted", halted, m_halt);
        chk("cycle_count", cycle_count, m_cycle);
        chk("instret", instret, m_instret);
        if (mq.size() != 0) chk("head", head_obs(), mq[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        ret_valid = 0; ret_pc = '0; ret_imm = '0; ret_rs1 = '0; ret_rs2 = '0; ret_rd = '0;
        ret_regwrite = 0; ret_exception = 0; clr = 0; t_ready = 0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                          input logic rw, input logic exc);
        ret_valid = 1; ret_pc = pc; ret_imm = imm; ret_rd = rd;
        ret_rs1 = rd + 5'd1; ret_rs2 = rd + 5'd2; ret_regwrite = rw; ret_exception = exc;
    endtask

    logic [63:0] saved_instret;
    logic [63:0] saved_cycle;

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_t_valid", t_valid, 1'b0);
        chk("rst_level", level, '0);
        chk("rst_cycle", cycle_count, '0);
        rst = 0;

        // Single record
        retire(32'h100, 32'h10, 5'd5, 1'b1, 1'b0);
        tick();
        ret_valid = 0;
        chk("single_pc", t_pc, 32'h100);
        chk("single_seq", t_seq, 16'd0);
        chk("single_level", level, 1);
        chk("single_instret", instret, 64'd1);
        t_ready = 1;
        tick();
        chk("single_drain_valid", t_valid, 1'b0);
        t_ready = 0;

        // Fill and overflow
        saved_instret = m_instret;
        for (int i = 0; i < 20; i++) begin
            retire(32'(4 * i), 32'(i), 5'(i), 1'b1, 1'b0);
            tick();
        end
        ret_valid = 0;
        chk("fill_level", level, 16);
        chk("fill_overflow", overflow, 1'b1);
        chk("fill_drops", drop_count, 16'd4);
        chk("fill_instret", instret, saved_instret + 64'd20);
        t_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_pc", t_pc, 32'(4 * i));
            chk("drain_seq", t_seq, 16'(saved_instret + 64'(i)));
            tick();
        end
        t_ready = 0;

        // Full with simultaneous pop, then backpressure hold
        for (int i = 0; i < 16; i++) begin
            retire(32'h1000 + 32'(i), 32'hABC, 5'd3, 1'b0, 1'b0);
            tick();
        end
        retire(32'h2000, 32'h55, 5'd9, 1'b1, 1'b0);
        t_ready = 1;
        tick();
        chk("fullpop_level", level, 16);
        chk("fullpop_drops", drop_count, 16'd4);
        ret_valid = 0;
        t_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_pc", t_pc, 32'h1001);
        end

        // Exception freeze
        clr = 1;
        tick();
        clr = 0;
        saved_instret = m_instret;
        for (int i = 0; i < 10; i++) begin
            retire(32'h3000, 32'h0, 5'd0, 1'b0, 1'b1);
            if (i == 2) saved_cycle = m_cycle;
            tick();
        end
        chk("exc_level", level, 1);
        chk("exc_flag", t_exception, 1'b1);
        chk("exc_halted", halted, 1'b1);
        chk("exc_instret", instret, saved_instret + 64'd1);
        chk("exc_cycle_frozen", cycle_count, saved_cycle);
        ret_valid = 0; ret_exception = 0;
        clr = 1;
        tick();
        clr = 0;
        chk("exc_clr_halted", halted, 1'b0);
        chk("exc_clr_level", level, 0);
        chk("exc_clr_ovf", overflow, 1'b0);

        // Reset mid-operation: level 7 with overflow set
        for (int i = 0; i < 17; i++) begin
            retire(32'h4000 + 32'(i), 32'h1, 5'd7, 1'b1, 1'b0);
            tick();
        end
        ret_valid = 0;
        t_ready = 1;
        repeat (9) tick();
        t_ready = 0;
        chk("pre_rst_level", level, 7);
        chk("pre_rst_ovf", overflow, 1'b1);
        rst = 1;
        #1;
        chk("arst_t_valid", t_valid, 1'b0);
        chk("arst_head", head_obs(), '0);
        chk("arst_level", level, '0);
        chk("arst_ovf", overflow, 1'b0);
        chk("arst_drops", drop_count, '0);
        chk("arst_halted", halted, 1'b0);
        chk("arst_cycle", cycle_count, '0);
        chk("arst_instret", instret, '0);
        model_reset();
        #1;
        rst = 0;
        retire(32'h5000, 32'h2, 5'd1, 1'b1, 1'b0);
        tick();
        ret_valid = 0;
        chk("post_rst_seq", t_seq, 16'd0);

        // clr collision with level 3
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 3; i++) begin
            retire(32'h6000 + 32'(i), 32'h3, 5'd2, 1'b1, 1'b0);
            tick();
        end
        chk("coll_pre_level", level, 3);
        saved_instret = m_instret;
        clr = 1;
        retire(32'h6100, 32'h4, 5'd2, 1'b1, 1'b0);
        tick();
        clr = 0;
        ret_valid = 0;
        chk("coll_level", level, 0);
        chk("coll_instret", instret, saved_instret);
        chk("coll_drops", drop_count, 16'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            ret_valid     = ($urandom_range(0, 9) < 7);
            ret_pc        = $urandom;
            ret_imm       = $urandom;
            ret_rs1       = 5'($urandom_range(0, 31));
            ret_rs2       = 5'($urandom_range(0, 31));
            ret_rd        = 5'($urandom_range(0, 31));
            ret_regwrite  = 1'($urandom_range(0, 1));
            ret_exception = ($urandom_range(0, 59) == 0);
            clr           = m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 79) == 0);
            t_ready       = ($urandom_range(0, 9) < 4);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
